// File: rtl/fifo_flex_if.sv
// Handshake/status bundle for fifo_flex: producer/consumer side (master) and FIFO side (slave).
interface fifo_flex_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                  flush;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dout;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, wr_en, din, rd_en,
        input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  flush, wr_en, din, rd_en,
        output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/fifo_flex.sv
// Single-clock FIFO with arbitrary depth, standard or FWFT read, programmable
// almost-full/empty thresholds, write-while-full, flush and sticky error flags.
module fifo_flex #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2
) (
    input  logic        clk,
    input  logic        rst_,
    fifo_flex_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  overflow_q;
    logic                  underflow_q;

    logic empty_w;
    logic full_w;
    logic rd_acc;
    logic wr_acc;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CW'(DEPTH));
    assign rd_acc  = bus.rd_en & ~empty_w;
    // A full FIFO still takes a write when the same cycle frees a slot.
    assign wr_acc  = bus.wr_en & (~full_w | rd_acc);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            dout_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + PW'(1);
                dout_q <= mem[rd_ptr];
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (bus.wr_en && !wr_acc) begin
                overflow_q <= 1'b1;
            end
            if (bus.rd_en && !rd_acc) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (rst_ && !bus.flush && wr_acc) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    assign bus.dout         = (FWFT != 0) ? (empty_w ? '0 : mem[rd_ptr]) : dout_q;
    assign bus.count        = count_q;
    assign bus.empty        = empty_w;
    assign bus.full         = full_w;
    assign bus.almost_full  = (count_q >= CW'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= CW'(AE_LEVEL));
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_flex.sv
// Scoreboarded directed bench: a 16-deep standard-mode FIFO and a 5-deep FWFT FIFO.
module tb_fifo_flex;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    fifo_flex_if #(.DATA_WIDTH(8), .DEPTH(16)) a_if ();
    fifo_flex_if #(.DATA_WIDTH(8), .DEPTH(5))  b_if ();

    fifo_flex dut_a (
        .clk  (clk),
        .rst_ (rst_a),
        .bus  (a_if)
    );

    fifo_flex #(
        .DATA_WIDTH (8),
        .DEPTH      (5),
        .FWFT       (1),
        .AF_LEVEL   (4),
        .AE_LEVEL   (1)
    ) dut_b (
        .clk  (clk),
        .rst_ (rst_b),
        .bus  (b_if)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] a_q [$];
    logic [7:0] b_q [$];
    logic       a_rd_exp = 1'b0;
    logic       a_fire   = 1'b0;
    logic       b_rd_exp = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Standard mode: read data is visible the cycle after the accepted rd_en.
    always @(posedge clk) a_fire <= a_rd_exp;

    always @(negedge clk) begin
        if (a_fire) begin
            if (a_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_sb_empty: got dout %0h, required no read", a_if.dout);
            end else begin
                check("a_dout", {24'h0, a_if.dout}, {24'h0, a_q.pop_front()});
            end
        end
        if (b_rd_exp) begin
            if (b_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_sb_empty: got dout %0h, required no pop", b_if.dout);
            end else begin
                check("b_dout", {24'h0, b_if.dout}, {24'h0, b_q.pop_front()});
            end
        end
    end

    task automatic a_cyc(input logic w, input logic [7:0] d, input logic r,
                         input logic acc, input logic [7:0] e);
        a_if.wr_en = w;
        a_if.din   = d;
        a_if.rd_en = r;
        a_rd_exp   = acc;
        if (acc) a_q.push_back(e);
        @(posedge clk);
        #1;
        a_if.wr_en = 1'b0;
        a_if.rd_en = 1'b0;
        a_rd_exp   = 1'b0;
    endtask

    task automatic b_cyc(input logic w, input logic [7:0] d, input logic r,
                         input logic acc, input logic [7:0] e);
        b_if.wr_en = w;
        b_if.din   = d;
        b_if.rd_en = r;
        b_rd_exp   = acc;
        if (acc) b_q.push_back(e);
        @(posedge clk);
        #1;
        b_if.wr_en = 1'b0;
        b_if.rd_en = 1'b0;
        b_rd_exp   = 1'b0;
    endtask

    // Flags for the 16-deep FIFO: almost_full at >=14, almost_empty at <=2.
    task automatic a_stat(input string tag, input int cnt, input logic ov, input logic un);
        check({tag, ".count"}, a_if.count, cnt);
        check({tag, ".empty"}, a_if.empty, (cnt == 0));
        check({tag, ".full"},  a_if.full,  (cnt == 16));
        check({tag, ".ae"},    a_if.almost_empty, (cnt <= 2));
        check({tag, ".af"},    a_if.almost_full,  (cnt >= 14));
        check({tag, ".ovf"},   a_if.overflow,  ov);
        check({tag, ".udf"},   a_if.underflow, un);
    endtask

    // Flags for the 5-deep FIFO: almost_full at >=4, almost_empty at <=1.
    task automatic b_stat(input string tag, input int cnt);
        check({tag, ".count"}, b_if.count, cnt);
        check({tag, ".empty"}, b_if.empty, (cnt == 0));
        check({tag, ".full"},  b_if.full,  (cnt == 5));
        check({tag, ".ae"},    b_if.almost_empty, (cnt <= 1));
        check({tag, ".af"},    b_if.almost_full,  (cnt >= 4));
        check({tag, ".udf"},   b_if.underflow, 1'b0);
        check({tag, ".ovf"},   b_if.overflow,  1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        a_if.flush = 1'b0; a_if.wr_en = 1'b0; a_if.rd_en = 1'b0; a_if.din = '0;
        b_if.flush = 1'b0; b_if.wr_en = 1'b0; b_if.rd_en = 1'b0; b_if.din = '0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_a = 1'b1;
        rst_b = 1'b1;

        a_stat("a_rst", 0, 1'b0, 1'b0);
        check("a_rst.dout", {24'h0, a_if.dout}, 32'h0);

        for (int i = 1; i <= 16; i++) begin
            a_cyc(1'b1, 8'(i), 1'b0, 1'b0, 8'h00);
            a_stat($sformatf("a_wr%0d", i), i, 1'b0, 1'b0);
        end

        a_cyc(1'b1, 8'hAA, 1'b1, 1'b1, 8'h01);
        a_stat("a_wwf", 16, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            a_cyc(1'b0, 8'h00, 1'b1, 1'b1, (i < 15) ? 8'(i + 2) : 8'hAA);
            a_stat($sformatf("a_rd%0d", i), 15 - i, 1'b0, 1'b0);
        end

        a_cyc(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
        a_stat("a_udf", 0, 1'b0, 1'b1);
        check("a_udf.dout", {24'h0, a_if.dout}, 32'hAA);

        a_cyc(1'b1, 8'h55, 1'b1, 1'b0, 8'h00);
        a_stat("a_wr_empty", 1, 1'b0, 1'b1);
        check("a_wr_empty.dout", {24'h0, a_if.dout}, 32'hAA);

        a_cyc(1'b0, 8'h00, 1'b1, 1'b1, 8'h55);
        a_stat("a_rd55", 0, 1'b0, 1'b1);

        a_if.flush = 1'b1;
        a_cyc(1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
        a_if.flush = 1'b0;
        a_stat("a_flush1", 0, 1'b0, 1'b0);

        for (int i = 0; i < 16; i++) begin
            a_cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 8'h00);
        end
        a_cyc(1'b1, 8'hEE, 1'b0, 1'b0, 8'h00);
        a_stat("a_ovf", 16, 1'b1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            a_cyc(1'b0, 8'h00, 1'b1, 1'b1, 8'(8'h20 + i));
        end
        a_stat("a_half", 8, 1'b1, 1'b0);

        a_if.flush = 1'b1;
        a_cyc(1'b1, 8'h99, 1'b0, 1'b0, 8'h00);
        a_if.flush = 1'b0;
        a_stat("a_flush2", 0, 1'b0, 1'b0);
        check("a_flush2.dout", {24'h0, a_if.dout}, 32'h27);

        a_cyc(1'b1, 8'h31, 1'b0, 1'b0, 8'h00);
        a_cyc(1'b0, 8'h00, 1'b1, 1'b1, 8'h31);

        for (int i = 0; i < 8; i++) begin
            a_cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 8'h00);
        end
        a_stat("a_pre_rst", 8, 1'b0, 1'b0);
        rst_a = 1'b0;
        a_cyc(1'b1, 8'h77, 1'b1, 1'b0, 8'h00);
        rst_a = 1'b1;
        a_stat("a_mid_rst", 0, 1'b0, 1'b0);
        check("a_mid_rst.dout", {24'h0, a_if.dout}, 32'h0);

        a_cyc(1'b1, 8'h42, 1'b0, 1'b0, 8'h00);
        a_cyc(1'b0, 8'h00, 1'b1, 1'b1, 8'h42);

        // FWFT, depth 5: wrap both pointers and pop with zero read latency.
        b_stat("b_rst", 0);
        for (int i = 0; i < 5; i++) begin
            b_cyc(1'b1, 8'(8'h11 + i), 1'b0, 1'b0, 8'h00);
            if (i == 0) check("b_fall_through", {24'h0, b_if.dout}, 32'h11);
        end
        b_stat("b_fill", 5);

        for (int i = 0; i < 3; i++) begin
            b_cyc(1'b0, 8'h00, 1'b1, 1'b1, 8'(8'h11 + i));
        end
        b_stat("b_pop3", 2);

        for (int i = 0; i < 3; i++) begin
            b_cyc(1'b1, 8'(8'h16 + i), 1'b0, 1'b0, 8'h00);
        end
        b_stat("b_wrap", 5);

        for (int i = 0; i < 5; i++) begin
            b_cyc(1'b0, 8'h00, 1'b1, 1'b1, 8'(8'h14 + i));
        end
        b_stat("b_drain", 0);

        @(posedge clk);
        #1;
        check("a_sb_drained", a_q.size(), 0);
        check("b_sb_drained", b_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_flex.md
Name: fifo_flex

Overview:
- Parametrised synchronous single-clock FIFO; next generation of the team's basic FIFO.
- Adds:
  - non-power-of-two depth
  - selectable standard or first-word-fall-through (FWFT) read mode
  - programmable almost-full/almost-empty thresholds
  - occupancy count output
  - write-while-full when a read is accepted in the same cycle
  - synchronous flush
  - sticky overflow/underflow error flags
- Used as the general buffering primitive between streaming datapath stages.

Parameters:
DATA_WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of storage entries; any integer >=2, not restricted to powers of two
FWFT, 0, 0 = standard mode (registered dout, 1-cycle read latency); 1 = first-word-fall-through
AF_LEVEL, 14, almost_full asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty asserts when count <= AE_LEVEL (0..DEPTH-1)

Ports:
clk  input  1  clock, all logic on rising edge
rst_  input  1  synchronous, active-low reset
flush  input  1  synchronous clear of FIFO contents
wr_en  input  1  write request
din  input  DATA_WIDTH  write data
rd_en  input  1  read request (pop/acknowledge in FWFT mode)
dout  output  DATA_WIDTH  read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_LEVEL
almost_empty  output  1  count <= AE_LEVEL
count  output  $clog2(DEPTH+1)  current occupancy
overflow  output  1  sticky: write request rejected
underflow  output  1  sticky: read request rejected

Behaviour:
- Reset is sampled on the rising clk edge while rst_=0.
  - count=0, pointers=0, dout=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored data and any same-cycle requests.
- Priority: reset > flush > rd/wr.
- flush=1: pointers and count go to 0; overflow and underflow clear; wr_en/rd_en ignored that cycle; dout holds its value in standard mode.
- Read accept: rd_acc = rd_en & !empty.
- Write accept: wr_acc = wr_en & (!full | rd_acc).
  - A full FIFO accepts a write when a read is accepted in the same cycle; count is unchanged.
- When empty, a same-cycle write is accepted and the read is rejected. There is no pass-through of din to dout.
- count update:
  - +1 on wr_acc only
  - -1 on rd_acc only
  - unchanged on both or neither
- Pointers: each wraps from DEPTH-1 to 0 and advances only on its own accept.
- Flags are all derived from the registered count. They are valid the cycle after the operation that changed count, with no other latency.
- Standard mode (FWFT=0):
  - On rd_acc, dout <= mem[rd_ptr] at that edge, so it is visible the cycle after rd_en.
  - dout holds its value otherwise, including on a rejected read.
- FWFT mode (FWFT=1):
  - dout = mem[rd_ptr] whenever !empty; rd_en pops the presented word.
  - A word written at edge N appears on dout after edge N, when empty falls.
  - dout is don't-care while empty.
- Error flags:
  - overflow sets on wr_en & !wr_acc.
  - underflow sets on rd_en & !rd_acc.
  - Both stay set until reset or flush.
  - Rejected requests change no other state.

Test Plan:
- Defaults, FWFT=0: reset; write 0x01..0x10 on 16 consecutive cycles -> count=16; full=1 after the 16th edge; almost_full=1 after the 14th edge. Then 16 reads -> dout sequence 0x01..0x10, each one cycle after its rd_en; empty=1 after the last read.
- Full FIFO, wr_en=rd_en=1, din=0xAA -> dout=0x01, count stays 16, full stays 1, overflow=0. 0xAA is later read in order after 0x10.
- Empty FIFO, rd_en=1 -> underflow=1, dout unchanged, count=0. Then wr_en=rd_en=1 with din=0x55 -> write accepted, count=1, dout unchanged.
- DEPTH=5, FWFT=1: push 0x11..0x15, pop 3, push 0x16..0x18 -> count=5 with pointers wrapped. dout presents 0x14, 0x15, 0x16, 0x17, 0x18 across successive pops, with no read latency.
- Half-full FIFO, with overflow set by a write to full: assert flush with wr_en=1 -> count=0, empty=1, almost_empty=1, overflow=0, and the write is ignored.
- Write 8 words, then assert rst_=0 for one cycle while wr_en=rd_en=1 -> all flags take their reset values, count=0, dout=0.
